// File: rtl/spi_l1_ctrl.sv
// SPI master bit-timing controller (mode 0) feeding the L2 bit-send stage.
// Generates CS/SCK framing plus the work_en/work_pulse/data strobes for an LSB-first byte.
module spi_l1_ctrl #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tx_valid,
   input  logic [7:0] i_tx_data,
   output logic       o_tx_ready,
   output logic       o_work_en,
   output logic       o_work_pulse,
   output logic [7:0] o_data,
   output logic       o_sck,
   output logic       o_cs_n,
   output logic       o_byte_done,
   output logic       o_busy
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      SHIFT,
      LOAD,
      TRAIL
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DIV_W-1:0] r_div_cnt;
   logic [DIV_W-1:0] w_div_cnt_nxt;
   logic [3:0]       r_edge_cnt;
   logic [3:0]       w_edge_cnt_nxt;
   logic             r_sck;
   logic             w_sck_nxt;
   logic             r_cs_n;
   logic             w_cs_n_nxt;
   logic             r_work_en;
   logic             w_work_en_nxt;
   logic             r_work_pulse;
   logic             w_work_pulse_nxt;
   logic             r_byte_done;
   logic             w_byte_done_nxt;
   logic [7:0]       r_data;
   logic [7:0]       w_data_nxt;
   logic             w_accept;
   logic             w_div_last;

   assign o_tx_ready   = (r_state == IDLE) || (r_state == LOAD);
   assign o_busy       = (r_state != IDLE);
   assign o_work_en    = r_work_en;
   assign o_work_pulse = r_work_pulse;
   assign o_data       = r_data;
   assign o_sck        = r_sck;
   assign o_cs_n       = r_cs_n;
   assign o_byte_done  = r_byte_done;

   assign w_accept   = i_tx_valid && o_tx_ready;
   assign w_div_last = (r_div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_div_cnt    <= '0;
         r_edge_cnt   <= '0;
         r_sck        <= 1'b0;
         r_cs_n       <= 1'b1;
         r_work_en    <= 1'b0;
         r_work_pulse <= 1'b0;
         r_byte_done  <= 1'b0;
         r_data       <= 8'h00;
      end else begin
         r_state      <= w_state_nxt;
         r_div_cnt    <= w_div_cnt_nxt;
         r_edge_cnt   <= w_edge_cnt_nxt;
         r_sck        <= w_sck_nxt;
         r_cs_n       <= w_cs_n_nxt;
         r_work_en    <= w_work_en_nxt;
         r_work_pulse <= w_work_pulse_nxt;
         r_byte_done  <= w_byte_done_nxt;
         r_data       <= w_data_nxt;
      end
   end

   // Every output is computed one cycle ahead here so the registered value lines up
   // with the cycle in which the state it belongs to is entered.
   always_comb begin
      w_state_nxt      = r_state;
      w_div_cnt_nxt    = r_div_cnt;
      w_edge_cnt_nxt   = r_edge_cnt;
      w_sck_nxt        = r_sck;
      w_cs_n_nxt       = r_cs_n;
      w_work_en_nxt    = r_work_en;
      w_work_pulse_nxt = 1'b0;
      w_byte_done_nxt  = 1'b0;
      w_data_nxt       = r_data;

      case (r_state)
         IDLE: begin
            w_sck_nxt     = 1'b0;
            w_cs_n_nxt    = 1'b1;
            w_work_en_nxt = 1'b0;
            if (w_accept) begin
               w_state_nxt      = LEAD;
               w_data_nxt       = i_tx_data;
               w_cs_n_nxt       = 1'b0;
               w_work_en_nxt    = 1'b1;
               w_work_pulse_nxt = 1'b1;
               w_div_cnt_nxt    = '0;
               w_edge_cnt_nxt   = '0;
            end
         end

         LEAD: begin
            if (w_div_last) begin
               w_state_nxt    = SHIFT;
               w_sck_nxt      = 1'b1;
               w_edge_cnt_nxt = 4'd1;
               w_div_cnt_nxt  = '0;
            end else begin
               w_div_cnt_nxt = r_div_cnt + 1'b1;
            end
         end

         // Edge 16 does not fit in 4 bits; it is recognised from edge 15 and the
         // counter wraps to 0 as the byte hands over to LOAD.
         SHIFT: begin
            if (w_div_last) begin
               w_div_cnt_nxt = '0;
               if (r_edge_cnt == 4'd15) begin
                  w_state_nxt     = LOAD;
                  w_sck_nxt       = 1'b0;
                  w_byte_done_nxt = 1'b1;
                  w_edge_cnt_nxt  = '0;
               end else begin
                  w_edge_cnt_nxt   = r_edge_cnt + 4'd1;
                  w_sck_nxt        = ~r_sck;
                  w_work_pulse_nxt = r_edge_cnt[0];
               end
            end else begin
               w_div_cnt_nxt = r_div_cnt + 1'b1;
            end
         end

         LOAD: begin
            w_div_cnt_nxt = '0;
            if (w_accept) begin
               w_state_nxt      = LEAD;
               w_data_nxt       = i_tx_data;
               w_work_pulse_nxt = 1'b1;
            end else begin
               w_state_nxt = TRAIL;
            end
         end

         TRAIL: begin
            if (w_div_last) begin
               w_state_nxt   = IDLE;
               w_cs_n_nxt    = 1'b1;
               w_work_en_nxt = 1'b0;
               w_div_cnt_nxt = '0;
            end else begin
               w_div_cnt_nxt = r_div_cnt + 1'b1;
            end
         end

         default: begin
            w_state_nxt   = IDLE;
            w_sck_nxt     = 1'b0;
            w_cs_n_nxt    = 1'b1;
            w_work_en_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_l1_ctrl.sv
// Self-checking bench for spi_l1_ctrl: two instances (CLK_DIV 4 and 2) checked every cycle
// against a timing model derived from the accept cycle, plus a model of the send stage.
module tb_spi_l1_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       txValid   [2];
   logic [7:0] txData    [2];
   logic       txReady   [2];
   logic       workEn    [2];
   logic       workPulse [2];
   logic [7:0] data      [2];
   logic       sck       [2];
   logic       csN       [2];
   logic       byteDone  [2];
   logic       busy      [2];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit checkOn = 1'b0;

   int         divOf    [2] = '{4, 2};
   bit         inFrame  [2];
   int         accCyc   [2];
   logic [7:0] expData  [2];
   logic       sdo      [2];
   logic       sdoPend  [2];
   int         bitIdx   [2];
   int         riseIdx  [2];
   logic       prevSck  [2];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   spi_l1_ctrl #(.CLK_DIV(4)) dut4 (
      .clk(clk), .rst(rst),
      .i_tx_valid(txValid[0]), .i_tx_data(txData[0]), .o_tx_ready(txReady[0]),
      .o_work_en(workEn[0]), .o_work_pulse(workPulse[0]), .o_data(data[0]),
      .o_sck(sck[0]), .o_cs_n(csN[0]), .o_byte_done(byteDone[0]), .o_busy(busy[0])
   );

   spi_l1_ctrl #(.CLK_DIV(2)) dut2 (
      .clk(clk), .rst(rst),
      .i_tx_valid(txValid[1]), .i_tx_data(txData[1]), .o_tx_ready(txReady[1]),
      .o_work_en(workEn[1]), .o_work_pulse(workPulse[1]), .o_data(data[1]),
      .o_sck(sck[1]), .o_cs_n(csN[1]), .o_byte_done(byteDone[1]), .o_busy(busy[1])
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, actual, expected);
      end
   endtask

   // Expected outputs as a function of cycles elapsed since the byte was accepted.
   // Packing: {ready, busy, cs_n, sck, work_en, work_pulse, byte_done, data[7:0]}.
   function automatic logic [14:0] expOuts(input bit inF, input int rel, input int d, input logic [7:0] byteV);
      logic rdy, bsy, cs, sk, we, pl, bd;
      rdy = 1'b1; bsy = 1'b0; cs = 1'b1; sk = 1'b0; we = 1'b0; pl = 1'b0; bd = 1'b0;
      if (inF && rel >= 1 && rel <= 17 * d + 1) begin
         rdy = 1'b0; bsy = 1'b1; cs = 1'b0; we = 1'b1;
         if (rel <= 16 * d) begin
            sk = (((rel - 1) / d) % 2) == 1;
            pl = ((rel - 1) % (2 * d) == 0) && (rel <= 1 + 14 * d);
         end else if (rel == 16 * d + 1) begin
            rdy = 1'b1;
            bd  = 1'b1;
         end
      end
      return {rdy, bsy, cs, sk, we, pl, bd, byteV};
   endfunction

   always @(negedge clk) begin
      if (checkOn) begin
         for (int i = 0; i < 2; i++) begin
            logic [14:0] e;
            logic [14:0] a;
            e = expOuts(inFrame[i], cyc - accCyc[i], divOf[i], expData[i]);
            a = {txReady[i], busy[i], csN[i], sck[i], workEn[i], workPulse[i], byteDone[i], data[i]};
            checkOutput(i == 0 ? "outs_div4" : "outs_div2", 32'(a), 32'(e));

            sdo[i] = sdoPend[i];
            if (sck[i] === 1'b1 && prevSck[i] === 1'b0 && riseIdx[i] < 8) begin
               checkOutput(i == 0 ? "sdo_div4" : "sdo_div2", 32'(sdo[i]), 32'(expData[i][riseIdx[i]]));
               riseIdx[i]++;
            end
            prevSck[i] = sck[i];
            if (workEn[i] !== 1'b1) bitIdx[i] = 0;
            if (workPulse[i] === 1'b1) begin
               sdoPend[i] = data[i][bitIdx[i][2:0]];
               bitIdx[i]  = (bitIdx[i] + 1) % 8;
            end

            if (rst) begin
               inFrame[i] = 1'b0;
               expData[i] = 8'h00;
            end else if (txValid[i] && e[14]) begin
               inFrame[i] = 1'b1;
               accCyc[i]  = cyc;
               expData[i] = txData[i];
               riseIdx[i] = 0;
            end
         end
      end
   end

   // Raise valid with a byte and hold it until the DUT takes it (bounded).
   task automatic applyStimulus(input int i, input logic [7:0] b);
      bit taken;
      taken = 1'b0;
      @(posedge clk); #1;
      txValid[i] = 1'b1;
      txData[i]  = b;
      for (int n = 0; n < 400 && !taken; n++) begin
         @(negedge clk);
         if (txReady[i] === 1'b1) taken = 1'b1;
      end
      checkOutput("accept_timeout", 32'(taken), 32'd1);
      @(posedge clk); #1;
      txValid[i] = 1'b0;
      txData[i]  = $urandom;
   endtask

   // Wait for byte_done and compare its cycle with the accept cycle (bounded).
   task automatic waitDone(input int i, input int expRel);
      bit seen;
      int startAcc;
      seen = 1'b0;
      startAcc = accCyc[i];
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge clk);
         if (byteDone[i] === 1'b1) seen = 1'b1;
      end
      checkOutput("done_seen", 32'(seen), 32'd1);
      if (seen) checkOutput("done_cycle", 32'(cyc - startAcc), 32'(expRel));
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         txValid[i] = 1'b0; txData[i] = 8'h00; inFrame[i] = 1'b0; accCyc[i] = 0;
         expData[i] = 8'h00; sdo[i] = 1'b0; sdoPend[i] = 1'b0; bitIdx[i] = 0;
         riseIdx[i] = 8; prevSck[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1 checkOn = 1'b1;
      @(posedge clk); #1 rst = 1'b0;

      $display("[TB] single byte A5, CLK_DIV=4");
      applyStimulus(0, 8'hA5);
      waitDone(0, 65);
      idleCycles(12);

      $display("[TB] back-to-back 3C, C3 with valid held during SHIFT");
      applyStimulus(0, 8'h3C);
      applyStimulus(0, 8'hC3);
      checkOutput("b2b_gap", 32'(accCyc[0]), 32'(accCyc[0]));
      waitDone(0, 65);
      idleCycles(12);

      $display("[TB] reset mid-byte then fresh byte");
      applyStimulus(0, 8'h96);
      idleCycles(27);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      idleCycles(3);
      applyStimulus(0, 8'h5A);
      waitDone(0, 65);
      idleCycles(12);

      $display("[TB] single byte FF, CLK_DIV=2");
      applyStimulus(1, 8'hFF);
      waitDone(1, 33);
      idleCycles(8);

      $display("[TB] random traffic");
      for (int k = 0; k < 24; k++) begin
         int i;
         i = $urandom_range(0, 1);
         applyStimulus(i, 8'($urandom));
         idleCycles($urandom_range(0, 80));
         if ($urandom_range(0, 7) == 0) begin
            #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
         end
      end
      idleCycles(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_l1_ctrl.md
# spi_l1_ctrl

SPI master bit-timing controller that sits directly upstream of the L2 bit-send stage. It accepts bytes over a valid/ready handshake, drives `o_cs_n` and `o_sck` (mode 0, idle low), and feeds the send stage its `work_en`, `work_pulse` and `data[7:0]` inputs. The send stage shifts the byte out LSB first, one bit per `work_pulse`.

## Interface
- `CLK_DIV`, default 4: SCK half-period in `clk` cycles; legal values are 2 and above.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_tx_valid`  in  1  upstream byte valid.
- `i_tx_data`  in  8  byte to send.
- `o_tx_ready`  out  1  combinational; high in IDLE and LOAD only. A byte transfers when `i_tx_valid && o_tx_ready`.
- `o_work_en`  out  1  to send stage `im_work_en`; high for the whole frame.
- `o_work_pulse`  out  1  to send stage `im_work_pulse`; one-cycle bit-advance strobe.
- `o_data`  out  8  to send stage `im_data`; latched byte, stable for the whole byte.
- `o_sck`  out  1  SPI clock.
- `o_cs_n`  out  1  SPI chip select, active low.
- `o_byte_done`  out  1  one-cycle pulse when the last SCK edge of a byte completes.
- `o_busy`  out  1  high whenever state is not IDLE.

## Operation
- All outputs are registered except `o_tx_ready` and `o_busy`, which decode the state directly.
- Reset values: state IDLE, `o_sck`=0, `o_cs_n`=1, `o_work_en`=0, `o_work_pulse`=0, `o_data`=8'h00, `o_byte_done`=0, all counters 0.
- Counters:
  - `div_cnt` counts 0..CLK_DIV-1, width $clog2(CLK_DIV).
  - `edge_cnt` is 4 bits and counts SCK edges 1..16 within a byte.
- IDLE: `o_cs_n`=1, `o_sck`=0, `o_work_en`=0. On accept, latch `o_data`<=`i_tx_data` and go to LEAD.
- LEAD: lasts CLK_DIV cycles.
  - `o_cs_n`=0, `o_work_en`=1.
  - `o_work_pulse`=1 in the first LEAD cycle only; this pulse is for bit 0.
  - At the end of LEAD, set `o_sck`=1 (edge 1) and go to SHIFT.
- SHIFT: toggle `o_sck` every CLK_DIV cycles.
  - Rising edges are the odd edges 1..15. Falling edges are the even edges 2..16.
  - `o_work_pulse`=1 in the cycle of falling edges 2,4,...,14 (bits 1..7). Edge 16 gets no pulse.
  - Exactly 8 pulses are issued per byte.
  - Edge 16 (`o_sck`=0) coincides with the transition into LOAD.
- LOAD: one cycle; `o_tx_ready`=1, `o_byte_done`=1, `o_sck`=0, `o_cs_n`=0.
  - If `i_tx_valid`: latch the new byte and go to LEAD. `o_cs_n` stays low, so the frame continues.
  - Otherwise go to TRAIL.
- TRAIL: `o_cs_n`=0, `o_sck`=0 for CLK_DIV cycles, then go to IDLE.
- `o_work_en` is high in LEAD, SHIFT, LOAD and TRAIL. The send stage's bit counter wraps 7->0 naturally between back-to-back bytes.
- `i_tx_valid` during LEAD, SHIFT or TRAIL is ignored (`o_tx_ready`=0). Upstream must hold the byte until LOAD or IDLE.
- Changes to `i_tx_data` outside the accept cycle have no effect.
- Reset asserted mid-operation: all outputs take their reset values in the next cycle. The in-flight byte is dropped and no `o_byte_done` is produced.

## Timing
- Cycle 0 is the accept cycle in IDLE (or in LOAD for a back-to-back byte).
- LEAD occupies cycles 1..CLK_DIV; the bit-0 pulse is in cycle 1.
- SCK edge k (k=1..16) is registered at cycle 1+k·CLK_DIV.
- Bit-n pulses (n=1..7) fall at cycle 1+2n·CLK_DIV.
- LOAD and `o_byte_done` fall at cycle 1+16·CLK_DIV.
- Back-to-back byte period is 16·CLK_DIV+1 cycles. The SCK low phase across the byte boundary is CLK_DIV+1 cycles.
- End of frame: TRAIL is CLK_DIV cycles, then `o_cs_n` rises. A new accept is possible in the first IDLE cycle, so `o_cs_n` is high for at least 1 cycle between frames.
- The send stage updates its data one cycle after each pulse. Every bit is therefore stable at least CLK_DIV-1 cycles before the following SCK rise.

## Test plan
- Single byte 8'hA5, CLK_DIV=4, accept at cycle 0:
  - Pulses at cycles 1,9,17,...,57; SCK rises at 5,13,...,61.
  - `o_byte_done` at cycle 65; `o_cs_n` rises at cycle 70.
  - The send-stage output sampled on SCK rises reads 1,0,1,0,0,1,0,1.
- Back-to-back 8'h3C then 8'hC3 with `i_tx_valid` held:
  - Second accept in LOAD at cycle 65; its bit-0 pulse at cycle 66.
  - `o_cs_n` stays low throughout; 16 pulses total; two `o_byte_done` pulses, 65 cycles apart.
- `i_tx_valid` raised at cycle 20 during SHIFT: `o_tx_ready` stays 0 until cycle 65 (LOAD), where the byte is accepted; no data corruption of the current byte.
- `rst` asserted at cycle 30 mid-byte: at cycle 31 `o_cs_n`=1, `o_sck`=0, `o_work_en`=0, `o_busy`=0, `o_data`=8'h00; no `o_byte_done`. A fresh byte after reset transfers normally.
- CLK_DIV=2, byte 8'hFF: SCK period 4 cycles, `o_byte_done` at cycle 33, 8 pulses, send-stage output high on all 8 rising edges.
